// File: rtl/enums_pkg.sv
// Shared enums and helpers for the core memory bus.
// Holds access sizes, bus FSM states and the misalignment rule.
package enums_pkg;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HALF  = 3'd1,
    WORD  = 3'd2,
    BYTEU = 3'd4,
    HALFU = 3'd5
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_bus_state_t;

  function automatic logic misaligned(
    input mem_size_t  size,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    case (size)
      HALF, HALFU: m = off[0];
      WORD:        m = |off;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and alignment/extension for loads.
// Purely combinational so cache and DMA blocks can share it.
module mem_lane_align
  import enums_pkg::*;
(
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic [31:0] store_data,
  output logic [31:0] lane_data,
  output logic [3:0]  byte_en,
  input  logic [31:0] load_word,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // steer store lanes, pick strobes, align and extend the load word
  always_comb begin
    lane_data = store_data << {offset, 3'b000};
    shifted   = load_word >> {offset, 3'b000};
    byte_en   = 4'b1111;
    load_data = shifted;
    case (size)
      BYTE: begin
        byte_en   = 4'b0001 << offset;
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      BYTEU: begin
        byte_en   = 4'b0001 << offset;
        load_data = {24'h0, shifted[7:0]};
      end
      HALF: begin
        byte_en   = 4'b0011 << offset;
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      HALFU: begin
        byte_en   = 4'b0011 << offset;
        load_data = {16'h0, shifted[15:0]};
      end
      default: begin
        byte_en   = 4'b1111;
        load_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_interconnect.sv
// Registered, handshaked core-to-peripheral bus with ack/error.
// Optional WAIT timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_interconnect
  import enums_pkg::*;
#(
  parameter int NUM_PERIPHERALS = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [31:0]                     address,
  input  mem_size_t                       size,
  input  logic                            read_enable,
  input  logic                            write_enable,
  input  logic [31:0]                     write_data,
  output logic [31:0]                     read_data,
  output logic                            ack,
  output logic                            bus_error,
  output logic [31:0]                     per_address,
  output logic [31:0]                     per_write_data,
  output logic [3:0]                      per_byte_en,
  output logic [NUM_PERIPHERALS-1:0]      read_enables,
  output logic [NUM_PERIPHERALS-1:0]      write_enables,
  input  logic [NUM_PERIPHERALS-1:0][31:0] read_datas,
  input  logic [NUM_PERIPHERALS-1:0]      ready_ins
);

  localparam int NP = NUM_PERIPHERALS;
  localparam int SW = $clog2(NP);

  mem_bus_state_t state_q, state_d;

  logic [SW-1:0] sel, sel_q;
  logic [NP-1:0] hot;
  logic          rd_q, req, err_req, rdy;
  logic [31:0]   lane_data, load_data;
  logic [3:0]    lane_be;
  logic          expired, drop;

  assign sel     = address[31 -: SW];
  assign hot     = {{(NP-1){1'b0}}, 1'b1} << sel;
  assign req     = read_enable | write_enable;
  assign err_req = (read_enable & write_enable) |
                   misaligned(size, address[1:0]);
  assign rdy     = ready_ins[sel_q];

  mem_lane_align u_align (
    .offset     (address[1:0]),
    .size       (size),
    .store_data (write_data),
    .lane_data  (lane_data),
    .byte_en    (lane_be),
    .load_word  (read_datas[sel_q]),
    .load_data  (load_data)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expired = (cnt_q == TO_MAX);
  assign drop    = (cnt_q == TO_LAST);

  // count WAIT cycles; strobes drop after the last one, error one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (state_q != WAIT)
      cnt_q <= '0;
    else if (!expired)
      cnt_q <= cnt_q + 1'b1;
  end
`else
  assign expired = 1'b0;
  assign drop    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = err_req ? RESP : WAIT;
      WAIT: if (rdy || expired) state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // completion pulse
  always_comb begin
    ack = (state_q == RESP);
  end

  // peripheral-side registers and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data      <= '0;
      bus_error      <= 1'b0;
      per_address    <= '0;
      per_write_data <= '0;
      per_byte_en    <= '0;
      read_enables   <= '0;
      write_enables  <= '0;
      sel_q          <= '0;
      rd_q           <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req && err_req) begin
            bus_error <= 1'b1;
          end else if (req) begin
            per_address    <= {{SW{1'b0}}, address[31-SW:0]};
            per_write_data <= lane_data;
            per_byte_en    <= lane_be;
            read_enables   <= read_enable ? hot : '0;
            write_enables  <= write_enable ? hot : '0;
            sel_q          <= sel;
            rd_q           <= read_enable;
          end
        end
        WAIT: begin
          if (rdy) begin
            read_enables  <= '0;
            write_enables <= '0;
            if (rd_q) read_data <= load_data;
          end else if (expired) begin
            bus_error     <= 1'b1;
            read_enables  <= '0;
            write_enables <= '0;
          end else if (drop) begin
            read_enables  <= '0;
            write_enables <= '0;
          end
        end
        RESP: begin
          read_data <= '0;
          bus_error <= 1'b0;
        end
        default: begin
          read_data <= '0;
          bus_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
